// File: rtl/ir_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// Fetch/control side is master, the queue is slave.
interface ir_queue_if #(
    parameter int IW    = 16,
    parameter int DEPTH = 4
);
    logic                           il_in;
    logic [IW-1:0]                  ins_in;
    logic                           next_in;
    logic                           flush_in;
    logic [IW-1:0]                  ins_out;
    logic [IW-1:0]                  ia_out;
    logic [IW-1:0]                  iv_out;
    logic                           valid_out;
    logic                           full_out;
    logic [$clog2(DEPTH+1)-1:0]     count_out;
    logic                           ovf_out;

    modport master (
        output il_in, ins_in, next_in, flush_in,
        input  ins_out, ia_out, iv_out, valid_out,
        input  full_out, count_out, ovf_out
    );

    modport slave (
        input  il_in, ins_in, next_in, flush_in,
        output ins_out, ia_out, iv_out, valid_out,
        output full_out, count_out, ovf_out
    );
endinterface

// File: rtl/ir_queue.sv
// Circular instruction queue with flush, occupancy and sticky overflow.
// Define IR_BYPASS_EN for empty-queue fall-through from ins_in.
module ir_queue #(
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    parameter int FW    = 8
) (
    input logic       clk,
    input logic       rst,
    ir_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          empty;
    logic          full;
    logic          byp;
    logic          head_vld;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [IW-1:0] head;

    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CW'(DEPTH));
`ifdef IR_BYPASS_EN
        byp = empty && q.il_in && !q.flush_in;
`else
        byp = 1'b0;
`endif
        head_vld = !empty || byp;
        pop      = q.next_in && head_vld && !q.flush_in;
        push     = q.il_in && (!full || pop) && !q.flush_in;
        // A bypassed word that is consumed at once never lands in storage
        wr_en    = push && !(byp && pop);
        drop     = q.il_in && full && !pop && !q.flush_in;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (q.flush_in) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (wr_en)
                wptr_d = wptr_q + 1'b1;
            if (pop && !byp)
                rptr_d = rptr_q + 1'b1;
            if (push && !pop)
                cnt_d = cnt_q + 1'b1;
            else if (pop && !push)
                cnt_d = cnt_q - 1'b1;
            if (drop)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wptr_q] <= q.ins_in;
    end

    always_comb begin
        if (byp)
            head = q.ins_in;
        else if (empty)
            head = '0;
        else
            head = mem_q[rptr_q];
    end

    assign q.ins_out   = head;
    assign q.valid_out = head_vld;
    assign q.full_out  = full;
    assign q.count_out = cnt_q;
    assign q.ovf_out   = ovf_q;

    generate
        if (FW == IW) begin : g_full_field
            assign q.ia_out = head;
            assign q.iv_out = head;
        end else begin : g_part_field
            assign q.ia_out = {{(IW-FW){1'b0}}, head[FW-1:0]};
            assign q.iv_out = {{(IW-FW){head[FW-1]}}, head[FW-1:0]};
        end
    endgenerate
endmodule

// File: tb/tb_ir_queue.sv
// Randomised + directed bench for ir_queue against a queue-based model.
// Define IR_BYPASS_EN to exercise the fall-through build.
module tb_ir_queue;
    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int FW    = 8;
`ifdef IR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_queue_if #(.IW(IW), .DEPTH(DEPTH)) bus ();

    ir_queue #(.IW(IW), .DEPTH(DEPTH), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    int tests = 0;
    int fails = 0;
    int mq[$];
    bit movf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic il, input logic [IW-1:0] ins,
                         input logic nx, input logic fl);
        bus.il_in    = il;
        bus.ins_in   = ins;
        bus.next_in  = nx;
        bus.flush_in = fl;
    endtask

    task automatic check_model();
        int n;
        logic bv;
        logic [IW-1:0] h, m, ia, iv;
        n  = mq.size();
        bv = BYP && n == 0 && bus.il_in && !bus.flush_in;
        if (n > 0) h = IW'(mq[0]);
        else if (bv) h = bus.ins_in;
        else h = '0;
        m  = IW'((32'd1 << FW) - 1);
        ia = h & m;
        iv = h[FW-1] ? (ia | ~m) : ia;
        chk("valid", 32'(bus.valid_out), 32'((n > 0) || bv));
        chk("ins",   32'(bus.ins_out),   32'(h));
        chk("ia",    32'(bus.ia_out),    32'(ia));
        chk("iv",    32'(bus.iv_out),    32'(iv));
        chk("count", 32'(bus.count_out), 32'(n));
        chk("full",  32'(bus.full_out),  32'(n == DEPTH));
        chk("ovf",   32'(bus.ovf_out),   32'(movf));
    endtask

    task automatic update_model();
        bit pop, push;
        if (rst || bus.flush_in) begin
            mq.delete();
            movf = 1'b0;
        end else if (BYP && mq.size() == 0 && bus.il_in && bus.next_in) begin
            // fall-through word consumed in the same cycle
        end else begin
            pop  = bus.next_in && mq.size() > 0;
            push = bus.il_in && (mq.size() < DEPTH || pop);
            if (bus.il_in && !push) movf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(int'(bus.ins_in));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_peek();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mq.delete();
        movf = 1'b0;
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_count", 32'(bus.count_out), 32'd0);
        chk("rst_full",  32'(bus.full_out),  32'd0);
        chk("rst_ovf",   32'(bus.ovf_out),   32'd0);
        chk("rst_ins",   32'(bus.ins_out),   32'd0);
        rst = 1'b0;

        drive(1'b1, 16'h12F0, 1'b0, 1'b0);
        step();
        idle_peek();
        chk("x1_ins",   32'(bus.ins_out),   32'h12F0);
        chk("x1_ia",    32'(bus.ia_out),    32'h00F0);
        chk("x1_iv",    32'(bus.iv_out),    32'hFFF0);
        chk("x1_count", 32'(bus.count_out), 32'd1);
        chk("x1_valid", 32'(bus.valid_out), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, IW'(i), 1'b0, 1'b0);
            step();
        end
        idle_peek();
        chk("fill_full",  32'(bus.full_out),  32'd1);
        chk("fill_count", 32'(bus.count_out), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            chk("pop_head", 32'(bus.ins_out), 32'(i));
            step();
        end
        idle_peek();
        chk("drain_valid", 32'(bus.valid_out), 32'd0);
        chk("drain_ins",   32'(bus.ins_out),   32'd0);
        chk("drain_iv",    32'(bus.iv_out),    32'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, IW'(16'h0011 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        step();
        idle_peek();
        chk("drop_ovf",   32'(bus.ovf_out),   32'd1);
        chk("drop_count", 32'(bus.count_out), 32'd4);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        step();
        idle_peek();
        chk("pp_full_count", 32'(bus.count_out), 32'd4);
        chk("pp_full_ovf",   32'(bus.ovf_out),   32'd1);
        chk("pp_full_head",  32'(bus.ins_out),   32'h0012);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();
        idle_peek();
        chk("two_count", 32'(bus.count_out), 32'd2);
        drive(1'b1, 16'h5555, 1'b1, 1'b1);
        step();
        idle_peek();
        chk("flush_count", 32'(bus.count_out), 32'd0);
        chk("flush_valid", 32'(bus.valid_out), 32'd0);
        chk("flush_ovf",   32'(bus.ovf_out),   32'd0);

        drive(1'b1, 16'h0100, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0101, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, IW'(16'h0102 + i), 1'b1, 1'b0);
            step();
        end
        idle_peek();
        chk("wrap_count", 32'(bus.count_out), 32'd2);
        chk("wrap_head",  32'(bus.ins_out),   32'h0114);
        drive(1'b0, '0, 1'b0, 1'b1);
        step();

`ifdef IR_BYPASS_EN
        drive(1'b1, 16'h00A5, 1'b1, 1'b0);
        #1;
        chk("byp_valid", 32'(bus.valid_out), 32'd1);
        chk("byp_ins",   32'(bus.ins_out),   32'h00A5);
        step();
        idle_peek();
        chk("byp_count", 32'(bus.count_out), 32'd0);
`else
        drive(1'b1, 16'h00A5, 1'b1, 1'b0);
        #1;
        chk("nobyp_valid", 32'(bus.valid_out), 32'd0);
        chk("nobyp_ins",   32'(bus.ins_out),   32'd0);
        step();
        idle_peek();
        chk("nobyp_count", 32'(bus.count_out), 32'd1);
        chk("nobyp_head",  32'(bus.ins_out),   32'h00A5);
`endif

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 60, IW'($urandom),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 4);
            step();
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register in mycpu.
- Holds up to DEPTH fetched instruction words in a circular buffer.
- Presents the head entry to decode with two pre-extracted fields: a zero-extended address field (ia_out) and a sign-extended immediate (iv_out).
- Sits between the fetch unit (writes via il_in) and the control FSM (consumes via next_in). Adds flush, occupancy count and sticky overflow reporting, which the single register did not have.

Parameters:
- IW, 16: instruction word width in bits.
- DEPTH, 4: number of entries. Must be a power of 2 and at least 2.
- FW, 8: width of the low instruction field used for ia_out/iv_out. Must satisfy 1 <= FW <= IW.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- il_in  in  1  instruction load (push) strobe.
- ins_in  in  IW  instruction word to push.
- next_in  in  1  consume (pop) the head entry.
- flush_in  in  1  discard all entries (branch taken).
- ins_out  out  IW  head instruction word.
- ia_out  out  IW  zero-extended ins_out[FW-1:0].
- iv_out  out  IW  sign-extended ins_out[FW-1:0].
- valid_out  out  1  head entry present.
- full_out  out  1  count == DEPTH.
- count_out  out  $clog2(DEPTH+1)  number of stored entries.
- ovf_out  out  1  sticky: a push was dropped.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Read/write pointers, count and ovf cleared.
  - valid_out=0, full_out=0, count_out=0, ovf_out=0.
  - ins_out, ia_out and iv_out are 0.
  - Storage array contents are don't-care.
- Reset mid-operation discards all entries. There is no partial completion.
- push = il_in && (!full || pop). A push is accepted when full only if a pop occurs in the same cycle.
- pop = next_in && valid_out. next_in while empty is ignored; count does not underflow.
- Push with no pop: entry written at wptr, wptr+1, count+1.
- Pop with no push: rptr+1, count-1.
- Push and pop together: both pointers advance, count unchanged.
- Pointers wrap modulo DEPTH.
- Dropped push (il_in && full && !pop): the word is discarded, and ovf_out goes to 1 on the next edge. ovf_out is cleared only by rst or flush_in.
- flush_in:
  - Takes priority over il_in and next_in in the same cycle.
  - Next edge: pointers=0, count=0, ovf=0.
  - The concurrent push is discarded and does not set ovf.
- Latency: a word pushed into an empty queue appears on ins_out with valid_out=1 one cycle after the push edge.
- Head outputs are combinational from storage[rptr]. When valid_out=0, ins_out, ia_out and iv_out are forced to 0.
- Field extraction:
  - ia_out = {(IW-FW)'0, ins_out[FW-1:0]}.
  - iv_out = {(IW-FW){ins_out[FW-1]}, ins_out[FW-1:0]}.
  - When FW==IW, both equal ins_out.
- full_out and count_out are registered-state derived; no combinational path from il_in or next_in.

Optional Feature:
- IR_BYPASS_EN defined: fall-through when the queue is empty (count==0, no flush_in).
  - il_in drives ins_out, ia_out and iv_out combinationally from ins_in, and valid_out=1 in the same cycle.
  - If next_in is also high, the word is consumed and not written; count stays 0.
  - Otherwise the word is written normally.
- IR_BYPASS_EN undefined: one-cycle latency as above. There is no combinational path from il_in/ins_in to any output.

Test Plan:
- Reset, then push 0x12F0 with FW=8, no pop → next cycle: valid_out=1, ins_out=0x12F0, ia_out=0x00F0, iv_out=0xFFF0, count_out=1.
- Push 0x0001..0x0004 on consecutive cycles → full_out=1, count_out=4. Then pop 4 times → heads 0x0001, 0x0002, 0x0003, 0x0004 in order; afterwards valid_out=0 and outputs 0.
- Full queue plus il_in with next_in=0 → word dropped, ovf_out=1, count stays 4. Repeat with next_in=1 → push accepted, count stays 4, ovf unchanged.
- Two entries, then flush_in=1 with il_in=1 and next_in=1 in the same cycle → next cycle: count_out=0, valid_out=0, ovf_out=0.
- 20 push/pop cycles with simultaneous push and pop at count=2 → pointers wrap, count_out stays 2, output order matches push order.
- With IR_BYPASS_EN, empty queue, il_in=1, ins_in=0x00A5, next_in=1 → same cycle: valid_out=1, ins_out=0x00A5; next cycle: count_out=0.
